rbs_unwind_ctl: RTL and testbench
=================================

Name: rbs_unwind_ctl

Overview:
- Sequences rollback of the SPA register backup stack (RBS) after a fault.
- The RBS records autoincrement/autodecrement side effects as {add_h, dsize[1:0], rnum[3:0]}.
- Per entry: pops the entry, arbitrates for the GPR scratchpad port, reads the GPR, writes back the corrected value, repeats until the stack is empty.
- Sits beside the SPA and GPR scratchpad. Granted by the microcode scratchpad arbiter.

Parameters:
- DATA_W, 32, GPR data width.
- DEPTH, 6, maximum RBS entries.
- CNT_W, 3, width of entry count.

Ports:
- m_clk_l  in  1  system clock; all state updates on rising edge of m_clk_l
- reset_h  in  1  asynchronous active-high reset
- start_h  in  1  begin unwind; sampled in IDLE only
- abort_h  in  1  cancel unwind; effective in any state
- rbs_cnt_h  in  CNT_W  number of valid RBS entries at start
- rbs_q_h  in  7  current top RBS entry {add, dsize[1:0], rnum[3:0]}
- rbs_pop_h  out  1  pop top entry (one-cycle pulse)
- sp_req_h  out  1  scratchpad port request
- sp_gnt_h  in  1  scratchpad port grant
- gpr_addr_h  out  4  GPR number for read/write
- gpr_rd_h  out  1  GPR read strobe
- gpr_rdata_h  in  DATA_W  GPR read data; valid in the cycle gpr_rd_h is high
- gpr_wr_h  out  1  GPR write strobe
- gpr_wdata_h  out  DATA_W  corrected GPR value
- busy_h  out  1  unwind in progress
- done_h  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; remaining count 0; entry and data registers 0. All outputs 0.
- Interface is exactly as decided: one clock (m_clk_l); reset_h is asynchronous and active-high.
- States: IDLE, POP, REQ, RD, WR, DONE.
- IDLE:
  - start_h=1 and rbs_cnt_h != 0 -> POP; load remaining = min(rbs_cnt_h, DEPTH).
  - start_h=1 and rbs_cnt_h == 0 -> DONE.
- POP: rbs_pop_h=1. Latch rbs_q_h into the entry register at end of cycle (pre-pop value) -> REQ.
- REQ: sp_req_h=1. Stay until sp_gnt_h=1, then -> RD.
- RD: sp_req_h=1, gpr_rd_h=1, gpr_addr_h=entry.rnum. Latch gpr_rdata_h -> WR.
- WR:
  - sp_req_h=1, gpr_wr_h=1, gpr_addr_h=entry.rnum, gpr_wdata_h = corrected value.
  - Decrement remaining. Next state DONE if remaining becomes 0, else POP.
- DONE: done_h=1 for one cycle -> IDLE.
- busy_h=1 in POP, REQ, RD, WR. It is 0 in IDLE and DONE.
- Size decode from dsize: 00=1, 01=2, 10=4, 11=8.
- Correction:
  - add=1 (autoincrement was applied): wdata = rdata - size.
  - add=0: wdata = rdata + size.
  - Modulo 2^DATA_W; wraps silently (0 - 1 = all ones).
- Grant is sampled only in REQ. Once granted, the port is held through RD and WR. Deasserting sp_gnt_h in RD/WR has no effect; the arbiter must not revoke while sp_req_h=1.
- gpr_addr_h and gpr_wdata_h are 0 outside RD/WR.
- Latency with sp_gnt_h tied high: 4 cycles per entry plus 1 DONE cycle.
- abort_h=1:
  - Next edge -> IDLE, remaining cleared, all strobes 0.
  - done_h is not pulsed. A write in progress is not retracted.
  - abort_h has priority over start_h in IDLE.
- start_h while busy_h=1 is ignored.

Optional Feature:
- Macro: RBS_UNWIND_PC_SKIP_EN.
- Defined: entries with rnum=15 (PC) are not corrected. After POP the FSM skips REQ/RD/WR, decrements remaining, and goes to POP or DONE (2 cycles for that entry: POP plus one skip cycle); no sp_req_h.
- Undefined: PC entries are corrected like any other GPR.

Test Plan:
- rbs_cnt_h=1, entry {1,10,0011}, gnt high, gpr_rdata_h=0x00001004 -> gpr_wr_h with addr 3, wdata 0x00001000; done_h 5 cycles after start sampled.
- rbs_cnt_h=2, entries {0,11,0101} then {1,00,0110}, rdata 0x100 both -> writes R5=0x108 then R6=0x0FF; two rbs_pop_h pulses; done_h at cycle 9.
- rbs_cnt_h=0, start_h=1 -> done_h next cycle; no pop, req, or strobes; busy_h stays 0.
- sp_gnt_h held low 5 cycles in REQ -> sp_req_h high throughout, no gpr_rd_h until grant; then RD, WR proceed normally.
- abort_h in RD of a 3-entry unwind -> IDLE next edge, busy_h=0, no done_h, no further pops; new start_h accepted afterwards.
- Wrap: entry {1,00,0001}, rdata 0x00000000 -> wdata 0xFFFFFFFF. With RBS_UNWIND_PC_SKIP_EN, entry rnum=15 -> no sp_req_h, done_h after 3 cycles.

Source files
------------

// File: rtl/rbs_unwind_ctl.sv
// Register backup stack unwind controller: pops RBS entries and undoes autoinc/autodec on GPRs.
// Optional macro RBS_UNWIND_PC_SKIP_EN leaves PC (rnum 15) entries uncorrected.
module rbs_unwind_ctl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 6,
  parameter int CNT_W  = 3
) (
  input  logic              m_clk_l,
  input  logic              reset_h,
  input  logic              start_h,
  input  logic              abort_h,
  input  logic [CNT_W-1:0]  rbs_cnt_h,
  input  logic [6:0]        rbs_q_h,
  output logic              rbs_pop_h,
  output logic              sp_req_h,
  input  logic              sp_gnt_h,
  output logic [3:0]        gpr_addr_h,
  output logic              gpr_rd_h,
  input  logic [DATA_W-1:0] gpr_rdata_h,
  output logic              gpr_wr_h,
  output logic [DATA_W-1:0] gpr_wdata_h,
  output logic              busy_h,
  output logic              done_h
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_POP  = 3'd1,
    ST_REQ  = 3'd2,
    ST_RD   = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5,
    ST_SKIP = 3'd6
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] remain_r;
  logic [CNT_W-1:0] remain_nxt_s;
  logic [6:0]       entry_r;
  logic [6:0]       entry_nxt_s;
  logic [CNT_W-1:0] load_cnt_s;
  logic             skip_s;

  // Undo one side effect: dsize selects 1/2/4/8, add bit selects direction; wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] correct_val(input logic [6:0] ent,
                                                     input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] size;
    size = {{(DATA_W-1){1'b0}}, 1'b1} << ent[5:4];
    if (ent[6]) begin
      correct_val = rdata - size;
    end else begin
      correct_val = rdata + size;
    end
  endfunction

  assign load_cnt_s = (rbs_cnt_h > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : rbs_cnt_h;

`ifdef RBS_UNWIND_PC_SKIP_EN
  assign skip_s = (rbs_q_h[3:0] == 4'hF);
`else
  assign skip_s = 1'b0;
`endif

  // Next-state, remaining-count and entry-latch logic.
  always_comb begin
    state_nxt_s  = state_r;
    remain_nxt_s = remain_r;
    entry_nxt_s  = entry_r;
    if (abort_h) begin
      state_nxt_s  = ST_IDLE;
      remain_nxt_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_h) begin
            if (rbs_cnt_h != {CNT_W{1'b0}}) begin
              state_nxt_s  = ST_POP;
              remain_nxt_s = load_cnt_s;
            end else begin
              state_nxt_s = ST_DONE;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_POP: begin
          entry_nxt_s = rbs_q_h;
          if (skip_s) begin
            state_nxt_s = ST_SKIP;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_REQ: begin
          if (sp_gnt_h) begin
            state_nxt_s = ST_RD;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_RD: state_nxt_s = ST_WR;
        ST_WR, ST_SKIP: begin
          remain_nxt_s = remain_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (remain_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_nxt_s  = ST_DONE;
            remain_nxt_s = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = ST_POP;
          end
        end
        ST_DONE: state_nxt_s = ST_IDLE;
        default: begin
          state_nxt_s  = ST_IDLE;
          remain_nxt_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, count and entry registers.
  always_ff @(posedge m_clk_l or posedge reset_h) begin
    if (reset_h) begin
      state_r  <= ST_IDLE;
      remain_r <= {CNT_W{1'b0}};
      entry_r  <= 7'd0;
    end else begin
      state_r  <= state_nxt_s;
      remain_r <= remain_nxt_s;
      entry_r  <= entry_nxt_s;
    end
  end

  // Outputs are registered from the next state so they align with the state they decode.
  always_ff @(posedge m_clk_l or posedge reset_h) begin
    if (reset_h) begin
      rbs_pop_h   <= 1'b0;
      sp_req_h    <= 1'b0;
      gpr_rd_h    <= 1'b0;
      gpr_wr_h    <= 1'b0;
      gpr_addr_h  <= 4'h0;
      gpr_wdata_h <= {DATA_W{1'b0}};
      busy_h      <= 1'b0;
      done_h      <= 1'b0;
    end else begin
      rbs_pop_h   <= (state_nxt_s == ST_POP);
      sp_req_h    <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_RD) || (state_nxt_s == ST_WR);
      gpr_rd_h    <= (state_nxt_s == ST_RD);
      gpr_wr_h    <= (state_nxt_s == ST_WR);
      gpr_addr_h  <= ((state_nxt_s == ST_RD) || (state_nxt_s == ST_WR)) ? entry_nxt_s[3:0] : 4'h0;
      gpr_wdata_h <= ((state_r == ST_RD) && (state_nxt_s == ST_WR)) ?
                     correct_val(entry_r, gpr_rdata_h) : {DATA_W{1'b0}};
      busy_h      <= (state_nxt_s == ST_POP) || (state_nxt_s == ST_REQ) ||
                     (state_nxt_s == ST_RD) || (state_nxt_s == ST_WR) || (state_nxt_s == ST_SKIP);
      done_h      <= (state_nxt_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_rbs_unwind_ctl.sv
// Directed table-driven bench for rbs_unwind_ctl plus hand sequences for reset and abort.
module tb_rbs_unwind_ctl;
  localparam int DATA_W = 32;

  logic        m_clk_l = 1'b0;
  logic        reset_h;
  logic        start_h;
  logic        abort_h;
  logic [2:0]  rbs_cnt_h;
  logic [6:0]  rbs_q_h;
  logic        rbs_pop_h;
  logic        sp_req_h;
  logic        sp_gnt_h;
  logic [3:0]  gpr_addr_h;
  logic        gpr_rd_h;
  logic [31:0] gpr_rdata_h;
  logic        gpr_wr_h;
  logic [31:0] gpr_wdata_h;
  logic        busy_h;
  logic        done_h;

  always #5 m_clk_l = ~m_clk_l;

  rbs_unwind_ctl #(.DATA_W(DATA_W), .DEPTH(6), .CNT_W(3)) dut (
    .m_clk_l(m_clk_l), .reset_h(reset_h), .start_h(start_h), .abort_h(abort_h),
    .rbs_cnt_h(rbs_cnt_h), .rbs_q_h(rbs_q_h), .rbs_pop_h(rbs_pop_h),
    .sp_req_h(sp_req_h), .sp_gnt_h(sp_gnt_h), .gpr_addr_h(gpr_addr_h),
    .gpr_rd_h(gpr_rd_h), .gpr_rdata_h(gpr_rdata_h), .gpr_wr_h(gpr_wr_h),
    .gpr_wdata_h(gpr_wdata_h), .busy_h(busy_h), .done_h(done_h)
  );

  typedef struct {
    logic [2:0]       cnt;
    logic [7:0][6:0]  ents;
    logic [31:0]      rdata;
    int               gnt_delay;
    int               exp_pops;
    int               exp_writes;
    int               exp_req;
    int               exp_busy;
    int               exp_done;
    logic [3:0]       a0;
    logic [31:0]      d0;
    logic [3:0]       a1;
    logic [31:0]      d1;
  } vec_t;

  int compared = 0;
  int mismatched = 0;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] cnt, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] efill, input logic [31:0] rdata, input int dly,
                               input int pops, input int writes, input int req, input int busy,
                               input int done, input logic [3:0] a0, input logic [31:0] d0,
                               input logic [3:0] a1, input logic [31:0] d1);
    vec_t v;
    for (int i = 0; i < 8; i++) v.ents[i] = efill;
    v.ents[0] = e0;
    v.ents[1] = e1;
    v.cnt = cnt; v.rdata = rdata; v.gnt_delay = dly;
    v.exp_pops = pops; v.exp_writes = writes; v.exp_req = req; v.exp_busy = busy;
    v.exp_done = done; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int pops, writes, reqc, busyc, donec, gcnt;
    logic [2:0]  pidx;
    logic [3:0]  wa[8];
    logic [31:0] wd[8];
    pops = 0; writes = 0; reqc = 0; busyc = 0; donec = -1; gcnt = 0;
    for (int i = 0; i < 8; i++) begin wa[i] = 4'h0; wd[i] = 32'h0; end
    @(negedge m_clk_l);
    start_h = 1'b1; rbs_cnt_h = v.cnt; rbs_q_h = v.ents[0];
    gpr_rdata_h = v.rdata; sp_gnt_h = 1'b0;
    for (int c = 1; c <= 80 && donec < 0; c++) begin
      @(negedge m_clk_l);
      start_h = 1'b0;
      if (rbs_pop_h) begin
        pops++; gcnt = 0; sp_gnt_h = 1'b0;
      end else begin
        pidx = pops[2:0];
        rbs_q_h = v.ents[pidx];
      end
      if (sp_req_h) reqc++;
      if (busy_h) busyc++;
      if (sp_req_h && !gpr_rd_h && !gpr_wr_h) begin
        gcnt++;
        sp_gnt_h = (gcnt > v.gnt_delay);
      end
      if (gpr_wr_h) begin
        if (writes < 8) begin wa[writes] = gpr_addr_h; wd[writes] = gpr_wdata_h; end
        writes++;
      end
      if (done_h) donec = c;
    end
    chk({tag, " done_cycle"}, donec, v.exp_done);
    chk({tag, " pops"}, pops, v.exp_pops);
    chk({tag, " writes"}, writes, v.exp_writes);
    chk({tag, " req_cycles"}, reqc, v.exp_req);
    chk({tag, " busy_cycles"}, busyc, v.exp_busy);
    if (v.exp_writes >= 1) begin
      chk({tag, " w0_addr"}, {28'h0, wa[0]}, {28'h0, v.a0});
      chk({tag, " w0_data"}, wd[0], v.d0);
    end
    if (v.exp_writes >= 2) begin
      chk({tag, " w1_addr"}, {28'h0, wa[1]}, {28'h0, v.a1});
      chk({tag, " w1_data"}, wd[1], v.d1);
    end
    @(negedge m_clk_l);
    chk({tag, " idle_busy"}, {31'h0, busy_h}, 32'h0);
    chk({tag, " idle_done"}, {31'h0, done_h}, 32'h0);
    sp_gnt_h = 1'b0;
  endtask

  initial begin
    int n_pop, n_done, n_busy;
    bit seen_rd;
    reset_h = 1'b1; start_h = 1'b0; abort_h = 1'b0; rbs_cnt_h = 3'd0; rbs_q_h = 7'd0;
    sp_gnt_h = 1'b0; gpr_rdata_h = 32'h0;

    vecs[0] = mkv(3'd1, 7'h63, 7'h00, 7'h00, 32'h0000_1004, 0, 1, 1, 3, 4, 5,
                  4'd3, 32'h0000_1000, 4'd0, 32'h0);
    vecs[1] = mkv(3'd2, 7'h35, 7'h46, 7'h00, 32'h0000_0100, 0, 2, 2, 6, 8, 9,
                  4'd5, 32'h0000_0108, 4'd6, 32'h0000_00FF);
    vecs[2] = mkv(3'd0, 7'h63, 7'h00, 7'h00, 32'h0000_1234, 0, 0, 0, 0, 0, 1,
                  4'd0, 32'h0, 4'd0, 32'h0);
    vecs[3] = mkv(3'd1, 7'h12, 7'h00, 7'h00, 32'h0000_0010, 5, 1, 1, 8, 9, 10,
                  4'd2, 32'h0000_0012, 4'd0, 32'h0);
    vecs[4] = mkv(3'd1, 7'h41, 7'h00, 7'h00, 32'h0000_0000, 0, 1, 1, 3, 4, 5,
                  4'd1, 32'hFFFF_FFFF, 4'd0, 32'h0);
    vecs[5] = mkv(3'd1, 7'h37, 7'h00, 7'h00, 32'hFFFF_FFFC, 0, 1, 1, 3, 4, 5,
                  4'd7, 32'h0000_0004, 4'd0, 32'h0);
    vecs[6] = mkv(3'd7, 7'h00, 7'h00, 7'h00, 32'h0000_0005, 0, 6, 6, 18, 24, 25,
                  4'd0, 32'h0000_0006, 4'd0, 32'h0000_0006);
`ifdef RBS_UNWIND_PC_SKIP_EN
    vecs[7] = mkv(3'd1, 7'h0F, 7'h00, 7'h00, 32'h0000_0020, 0, 1, 0, 0, 2, 3,
                  4'd0, 32'h0, 4'd0, 32'h0);
`else
    vecs[7] = mkv(3'd1, 7'h0F, 7'h00, 7'h00, 32'h0000_0020, 0, 1, 1, 3, 4, 5,
                  4'd15, 32'h0000_0021, 4'd0, 32'h0);
`endif

    repeat (2) @(negedge m_clk_l);
    chk("reset_outputs", {22'h0, rbs_pop_h, sp_req_h, gpr_rd_h, gpr_wr_h, busy_h, done_h, gpr_addr_h},
        32'h0);
    chk("reset_wdata", gpr_wdata_h, 32'h0);
    reset_h = 1'b0;
    @(negedge m_clk_l);
    chk("post_reset_idle", {26'h0, rbs_pop_h, sp_req_h, gpr_rd_h, gpr_wr_h, busy_h, done_h}, 32'h0);

    // Abort wins over start in IDLE.
    start_h = 1'b1; abort_h = 1'b1; rbs_cnt_h = 3'd2;
    @(negedge m_clk_l);
    start_h = 1'b0; abort_h = 1'b0;
    chk("abort_prio", {29'h0, busy_h, done_h, rbs_pop_h}, 32'h0);
    @(negedge m_clk_l);
    chk("abort_prio_later", {29'h0, busy_h, done_h, rbs_pop_h}, 32'h0);

    for (int i = 0; i < 8; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Abort while in RD of a 3-entry unwind.
    @(negedge m_clk_l);
    start_h = 1'b1; rbs_cnt_h = 3'd3; rbs_q_h = 7'h01; sp_gnt_h = 1'b1; gpr_rdata_h = 32'h40;
    seen_rd = 1'b0;
    for (int c = 0; c < 20 && !seen_rd; c++) begin
      @(negedge m_clk_l);
      start_h = 1'b0;
      if (gpr_rd_h) begin
        seen_rd = 1'b1;
        abort_h = 1'b1;
      end
    end
    chk("abort_reached_rd", {31'h0, seen_rd}, 32'h1);
    @(negedge m_clk_l);
    abort_h = 1'b0;
    chk("abort_idle", {27'h0, busy_h, sp_req_h, gpr_rd_h, gpr_wr_h, rbs_pop_h}, 32'h0);
    n_pop = 0; n_done = 0; n_busy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge m_clk_l);
      if (rbs_pop_h) n_pop++;
      if (done_h) n_done++;
      if (busy_h) n_busy++;
    end
    chk("abort_no_pop", n_pop, 0);
    chk("abort_no_done", n_done, 0);
    chk("abort_no_busy", n_busy, 0);
    sp_gnt_h = 1'b0;
    run(vecs[0], "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
